// File: rtl/vga_pkg.sv
// Shared VGA definitions: bus layout, screen defaults, colours and board/font field widths.
package vga_pkg;

    localparam int SCREEN_W_DEF = 1024;
    localparam int SCREEN_H_DEF = 768;

    localparam logic [11:0] COLOR_FONT_DEF   = 12'hfff;
    localparam logic [11:0] COLOR_CURSOR_DEF = 12'hf80;

    localparam int VAL_W = 5;
    typedef logic [VAL_W-1:0] cell_val_t;

    localparam int FONT_ROW_W  = 4;
    localparam int FONT_CODE_W = 7;
    localparam int FONT_ADDR_W = FONT_CODE_W + FONT_ROW_W;

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_bus_t;

endpackage

// File: rtl/vga_bus_delay.sv
// Delays every vga_bus field by STAGES clocks; used to keep timing aligned with pipelined overlays.
module vga_bus_delay
    import vga_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  vga_bus_t bus_in,
    output vga_bus_t bus_out
);

    vga_bus_t pipe [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= bus_in;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus_out = pipe[STAGES-1];

endmodule

// File: rtl/board_digits_overlay.sv
// Centred N x N board glyph overlay with cursor highlight; 3-cycle latency on the VGA bus.
// Optional cursor blinking is enabled by defining BOARD_OVERLAY_CURSOR_BLINK_EN.
module board_digits_overlay
    import vga_pkg::*;
#(
    parameter int          SCREEN_W     = SCREEN_W_DEF,
    parameter int          SCREEN_H     = SCREEN_H_DEF,
    parameter int          CELL_PX      = 32,
    parameter int          GLYPH_PX     = 16,
    parameter int          MAX_N        = 16,
    parameter int          VAL_W        = vga_pkg::VAL_W,
    parameter int          GLYPH_BASE   = 1,
    parameter logic [11:0] FONT_COLOR   = COLOR_FONT_DEF,
    parameter logic [11:0] CURSOR_COLOR = COLOR_CURSOR_DEF,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   is_game_on,
    input  logic [4:0]             board_side,
    input  logic [3:0]             cursor_row,
    input  logic [3:0]             cursor_col,
    output logic [3:0]             cell_row,
    output logic [3:0]             cell_col,
    input  logic [VAL_W-1:0]       cell_val,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [GLYPH_PX-1:0]    char_pixels,
    input  vga_bus_t               bus_in,
    output vga_bus_t               bus_out
);

    localparam int CELL_SH = $clog2(CELL_PX);
    localparam int DXW     = CELL_SH + 4;
    localparam int OW      = CELL_SH + 1;
    localparam int GX_W    = $clog2(GLYPH_PX);
    localparam logic [OW-1:0] G_LO = OW'((CELL_PX - GLYPH_PX) >> 1);
    localparam logic [OW-1:0] G_HI = OW'(((CELL_PX - GLYPH_PX) >> 1) + GLYPH_PX);

    logic [4:0] n_q;
    logic       vs_prev;
    logic       vs_rise;

    assign vs_rise = bus_in.vsync && !vs_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q     <= '0;
            vs_prev <= 1'b0;
        end else begin
            vs_prev <= bus_in.vsync;
            if (vs_rise) n_q <= board_side;
        end
    end

`ifdef BOARD_OVERLAY_CURSOR_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    logic [FC_W-1:0] frame_cnt;
    logic            blink_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (vs_rise) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    logic blink_on;
    assign blink_on = 1'b1;
`endif

    logic [15:0]     w, x0, y0, hc, vc;
    logic [DXW-1:0]  dx, dy;
    logic [OW-1:0]   ox, oy;
    logic [GX_W-1:0] gx, gy;
    logic            n_ok, in_board, in_glyph;

    // Geometry of the incoming pixel; offsets are only meaningful when in_board is set.
    always_comb begin
        w        = 16'(n_q) << CELL_SH;
        x0       = (16'(SCREEN_W) - w) >> 1;
        y0       = (16'(SCREEN_H) - w) >> 1;
        hc       = 16'(bus_in.hcount);
        vc       = 16'(bus_in.vcount);
        n_ok     = (n_q != 5'd0) && (16'(n_q) <= 16'(MAX_N));
        in_board = n_ok && !bus_in.hblnk && !bus_in.vblnk &&
                   (hc >= x0) && (hc < x0 + w) && (vc >= y0) && (vc < y0 + w);
        dx       = DXW'(hc - x0);
        dy       = DXW'(vc - y0);
        ox       = {1'b0, dx[CELL_SH-1:0]};
        oy       = {1'b0, dy[CELL_SH-1:0]};
        in_glyph = (ox >= G_LO) && (ox < G_HI) && (oy >= G_LO) && (oy < G_HI);
        gx       = GX_W'(ox - G_LO);
        gy       = GX_W'(oy - G_LO);
    end

    logic            vld_p0, cur_p0;
    logic [GX_W-1:0] gx_p0, gy_p0;

    // S0: board address and glyph-window flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cell_row <= '0;
            cell_col <= '0;
            vld_p0   <= 1'b0;
            cur_p0   <= 1'b0;
        end else begin
            cell_row <= dy[DXW-1:CELL_SH];
            cell_col <= dx[DXW-1:CELL_SH];
            vld_p0   <= is_game_on && in_board && in_glyph;
            cur_p0   <= (dy[DXW-1:CELL_SH] == cursor_row) && (dx[DXW-1:CELL_SH] == cursor_col) &&
                        ({1'b0, cursor_row} < n_q) && ({1'b0, cursor_col} < n_q);
        end
    end

    always_ff @(posedge clk) begin
        gx_p0 <= gx;
        gy_p0 <= gy;
    end

    logic                   vld_p1, cur_p1;
    logic [GX_W-1:0]        gx_p1;
    logic [FONT_CODE_W-1:0] code;

    assign code = FONT_CODE_W'(cell_val) + FONT_CODE_W'(GLYPH_BASE);

    // S1: cell value known, issue font row read
    always_ff @(posedge clk) begin
        if (rst) begin
            font_addr <= '0;
            vld_p1    <= 1'b0;
            cur_p1    <= 1'b0;
        end else begin
            font_addr <= {code, FONT_ROW_W'(gy_p0)};
            vld_p1    <= vld_p0 && (cell_val != '0) && (16'(cell_val) <= 16'(n_q));
            cur_p1    <= cur_p0;
        end
    end

    always_ff @(posedge clk) begin
        gx_p1 <= gx_p0;
    end

    vga_bus_t bus_p1;

    vga_bus_delay #(.STAGES(2)) u_bus_delay (
        .clk     (clk),
        .rst     (rst),
        .bus_in  (bus_in),
        .bus_out (bus_p1)
    );

    // S2: font row known; GLYPH_PX is a power of two so GLYPH_PX-1-gx is just ~gx
    logic [GX_W-1:0] bit_sel;
    logic            pix_on;
    logic [11:0]     rgb_nxt;

    always_comb begin
        bit_sel = ~gx_p1;
        pix_on  = vld_p1 && char_pixels[bit_sel];
        rgb_nxt = bus_p1.rgb;
        if (pix_on) rgb_nxt = (cur_p1 && blink_on) ? CURSOR_COLOR : FONT_COLOR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out <= '0;
        end else begin
            bus_out     <= bus_p1;
            bus_out.rgb <= rgb_nxt;
        end
    end

endmodule
